// File: rtl/writeback_arbiter_pkg.sv
// Shared types for the register file writeback arbiter.
// Address/data widths and the FIFO entry layout.
package writeback_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  typedef struct packed {
    reg_addr_t addr;
    data_t     data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Bundle of pipeline, MDU, decode and register file
// signals seen by the writeback arbiter.
interface writeback_arbiter_if;
  import writeback_arbiter_pkg::*;

  reg_addr_t   pipe_wr_addr;
  data_t       pipe_wr_data;
  logic        mdu_issue;
  reg_addr_t   mdu_issue_addr;
  logic        mdu_res_valid;
  reg_addr_t   mdu_res_addr;
  data_t       mdu_res_data;
  logic        mdu_res_ready;
  reg_addr_t   dec_rs_addr;
  reg_addr_t   dec_rt_addr;
  reg_addr_t   dec_rd_addr;
  logic        stall;
  logic        drain_req;
  reg_addr_t   rf_write_addr;
  data_t       rf_data_in;
  logic [31:0] busy_mask;

  modport slave (
    input  pipe_wr_addr, pipe_wr_data,
    input  mdu_issue, mdu_issue_addr,
    input  mdu_res_valid, mdu_res_addr,
    input  mdu_res_data,
    output mdu_res_ready,
    input  dec_rs_addr, dec_rt_addr,
    input  dec_rd_addr,
    output stall, drain_req,
    output rf_write_addr, rf_data_in,
    output busy_mask
  );

  modport master (
    output pipe_wr_addr, pipe_wr_data,
    output mdu_issue, mdu_issue_addr,
    output mdu_res_valid, mdu_res_addr,
    output mdu_res_data,
    input  mdu_res_ready,
    output dec_rs_addr, dec_rt_addr,
    output dec_rd_addr,
    input  stall, drain_req,
    input  rf_write_addr, rf_data_in,
    input  busy_mask
  );

endinterface

// File: rtl/wb_result_fifo.sv
// First-word-fall-through FIFO for MDU results.
// Push while full is taken only alongside a pop.
module wb_result_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  wb_entry_t     mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage; cleared on reset so head is never X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Register file write port arbiter: pipeline first,
// MDU results queued, scoreboard and starvation drain.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input logic clk,
  input logic rst_n,
  writeback_arbiter_if.slave bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic        full;
  logic        empty;
  wb_entry_t   head;
  wb_entry_t   din;
  logic        pipe_act;
  logic        pop;
  logic        push;
  logic [31:0] busy;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] starve_nxt;
  logic        drain_q;

  assign pipe_act = (bus.pipe_wr_addr != REG_ZERO);
  assign pop      = !pipe_act && !empty;
  assign push     = bus.mdu_res_valid && !full &&
                    (bus.mdu_res_addr != REG_ZERO);
  assign din      = '{addr: bus.mdu_res_addr,
                      data: bus.mdu_res_data};

  assign bus.mdu_res_ready = !full;
  assign bus.busy_mask     = busy;
  assign bus.drain_req     = drain_q;
  assign bus.stall = busy[bus.dec_rs_addr] |
                     busy[bus.dec_rt_addr] |
                     busy[bus.dec_rd_addr];

  wb_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // Write port mux: pipeline wins, else FIFO head.
  always_comb begin
    bus.rf_write_addr = REG_ZERO;
    bus.rf_data_in    = '0;
    if (pipe_act) begin
      bus.rf_write_addr = bus.pipe_wr_addr;
      bus.rf_data_in    = bus.pipe_wr_data;
    end else if (!empty) begin
      bus.rf_write_addr = head.addr;
      bus.rf_data_in    = head.data;
    end
  end

  // Scoreboard set/clear masks for this cycle.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (bus.mdu_issue && !bus.stall &&
        bus.mdu_issue_addr != REG_ZERO)
      set_mask[bus.mdu_issue_addr] = 1'b1;
    if (pop)
      clr_mask[head.addr] = 1'b1;
  end

  // Starvation counter next state, saturating.
  always_comb begin
    starve_nxt = starve_cnt;
    if (empty || pop)
      starve_nxt = '0;
    else if (starve_cnt < CW'(STARVE_LIMIT))
      starve_nxt = starve_cnt + CW'(1);
  end

  // Scoreboard: set wins over clear; r0 never busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy <= '0;
    else
      busy <= ((busy & ~clr_mask) | set_mask) &
              ~32'd1;
  end

  // Starvation state and registered drain request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      drain_q    <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      drain_q    <= (starve_nxt >= CW'(STARVE_LIMIT));
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed testbench for writeback_arbiter.
// Tasks per scenario; inline checks; one summary.
module tb_writeback_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  writeback_arbiter_if bus ();

  writeback_arbiter #(
    .DEPTH        (4),
    .STARVE_LIMIT (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.pipe_wr_addr   = 5'd0;
    bus.pipe_wr_data   = 32'd0;
    bus.mdu_issue      = 1'b0;
    bus.mdu_issue_addr = 5'd0;
    bus.mdu_res_valid  = 1'b0;
    bus.mdu_res_addr   = 5'd0;
    bus.mdu_res_data   = 32'd0;
    bus.dec_rs_addr    = 5'd0;
    bus.dec_rt_addr    = 5'd0;
    bus.dec_rd_addr    = 5'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #3;
    checks++;
    if (bus.rf_write_addr !== 5'd0) begin
      errors++;
      $display("FAIL rst_addr: got %0d expected 0",
               bus.rf_write_addr);
    end
    checks++;
    if (bus.mdu_res_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: got %b expected 1",
               bus.mdu_res_ready);
    end
    checks++;
    if (bus.stall !== 1'b0 || bus.drain_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_stall_drain: got %b%b expected 00",
               bus.stall, bus.drain_req);
    end
    checks++;
    if (bus.busy_mask !== 32'd0) begin
      errors++;
      $display("FAIL rst_busy: got %h expected 0",
               bus.busy_mask);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_pipe_write();
    bus.pipe_wr_addr = 5'd3;
    bus.pipe_wr_data = 32'h11;
    settle();
    checks++;
    if (bus.rf_write_addr !== 5'd3 ||
        bus.rf_data_in !== 32'h11) begin
      errors++;
      $display("FAIL pipe_write: got %0d/%h expected 3/11",
               bus.rf_write_addr, bus.rf_data_in);
    end
    tick();
    idle();
  endtask

  task automatic test_mdu_result();
    bus.mdu_issue      = 1'b1;
    bus.mdu_issue_addr = 5'd8;
    tick();
    bus.mdu_issue = 1'b0;
    bus.dec_rs_addr = 5'd8;
    settle();
    checks++;
    if (bus.busy_mask !== 32'h100 || bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL mdu_busy_set: got %h/%b expected 100/1",
               bus.busy_mask, bus.stall);
    end
    bus.mdu_res_valid = 1'b1;
    bus.mdu_res_addr  = 5'd8;
    bus.mdu_res_data  = 32'hBEEF;
    tick();
    bus.mdu_res_valid = 1'b0;
    settle();
    checks++;
    if (bus.rf_write_addr !== 5'd8 ||
        bus.rf_data_in !== 32'hBEEF ||
        bus.busy_mask[8] !== 1'b1) begin
      errors++;
      $display("FAIL mdu_write: got %0d/%h/%b expected 8/beef/1",
               bus.rf_write_addr, bus.rf_data_in,
               bus.busy_mask[8]);
    end
    tick();
    settle();
    checks++;
    if (bus.busy_mask !== 32'd0 || bus.stall !== 1'b0 ||
        bus.rf_write_addr !== 5'd0) begin
      errors++;
      $display("FAIL mdu_clear: got %h/%b/%0d expected 0/0/0",
               bus.busy_mask, bus.stall, bus.rf_write_addr);
    end
    idle();
  endtask

  task automatic test_starvation();
    bus.pipe_wr_addr  = 5'd4;
    bus.pipe_wr_data  = 32'h44;
    bus.mdu_res_valid = 1'b1;
    bus.mdu_res_addr  = 5'd9;
    bus.mdu_res_data  = 32'h5;
    tick();
    bus.mdu_res_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      settle();
      checks++;
      if (bus.rf_write_addr !== 5'd4 ||
          bus.drain_req !== 1'b0) begin
        errors++;
        $display("FAIL starve_c%0d: got %0d/%b expected 4/0",
                 c, bus.rf_write_addr, bus.drain_req);
      end
      tick();
    end
    bus.pipe_wr_addr = 5'd0;
    settle();
    checks++;
    if (bus.drain_req !== 1'b1 || bus.rf_write_addr !== 5'd9 ||
        bus.rf_data_in !== 32'h5) begin
      errors++;
      $display("FAIL starve_drain: got %b/%0d/%h expected 1/9/5",
               bus.drain_req, bus.rf_write_addr, bus.rf_data_in);
    end
    tick();
    settle();
    checks++;
    if (bus.drain_req !== 1'b0 || bus.rf_write_addr !== 5'd0) begin
      errors++;
      $display("FAIL starve_after: got %b/%0d expected 0/0",
               bus.drain_req, bus.rf_write_addr);
    end
    idle();
  endtask

  task automatic test_fifo_full();
    logic [4:0] exp_q [4];
    exp_q[0] = 5'd12;
    exp_q[1] = 5'd13;
    exp_q[2] = 5'd14;
    exp_q[3] = 5'd15;
    bus.pipe_wr_addr = 5'd5;
    bus.pipe_wr_data = 32'h55;
    for (int i = 0; i < 4; i++) begin
      bus.mdu_res_valid = 1'b1;
      bus.mdu_res_addr  = 5'(10 + i);
      bus.mdu_res_data  = 32'h100 + 32'(10 + i);
      settle();
      checks++;
      if (bus.mdu_res_ready !== 1'b1) begin
        errors++;
        $display("FAIL full_ready_%0d: got %b expected 1",
                 i, bus.mdu_res_ready);
      end
      tick();
    end
    bus.mdu_res_valid = 1'b0;
    settle();
    checks++;
    if (bus.mdu_res_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_not_ready: got %b expected 0",
               bus.mdu_res_ready);
    end
    bus.pipe_wr_addr = 5'd0;
    settle();
    checks++;
    if (bus.rf_write_addr !== 5'd10) begin
      errors++;
      $display("FAIL full_pop10: got %0d expected 10",
               bus.rf_write_addr);
    end
    tick();
    bus.mdu_res_valid = 1'b1;
    bus.mdu_res_addr  = 5'd14;
    bus.mdu_res_data  = 32'h10E;
    settle();
    checks++;
    if (bus.mdu_res_ready !== 1'b1 ||
        bus.rf_write_addr !== 5'd11) begin
      errors++;
      $display("FAIL full_pushpop: got %b/%0d expected 1/11",
               bus.mdu_res_ready, bus.rf_write_addr);
    end
    tick();
    bus.mdu_res_valid = 1'b0;
    settle();
    checks++;
    if (bus.mdu_res_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_count3: got %b expected 1",
               bus.mdu_res_ready);
    end
    bus.pipe_wr_addr  = 5'd5;
    bus.mdu_res_valid = 1'b1;
    bus.mdu_res_addr  = 5'd15;
    bus.mdu_res_data  = 32'h10F;
    tick();
    bus.mdu_res_valid = 1'b0;
    settle();
    checks++;
    if (bus.mdu_res_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_again: got %b expected 0",
               bus.mdu_res_ready);
    end
    bus.pipe_wr_addr = 5'd0;
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++;
      if (bus.rf_write_addr !== exp_q[i] ||
          bus.rf_data_in !== 32'h100 + 32'(exp_q[i])) begin
        errors++;
        $display("FAIL full_order_%0d: got %0d/%h expected %0d/%h",
                 i, bus.rf_write_addr, bus.rf_data_in,
                 exp_q[i], 32'h100 + 32'(exp_q[i]));
      end
      tick();
    end
    settle();
    checks++;
    if (bus.rf_write_addr !== 5'd0 ||
        bus.mdu_res_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_empty: got %0d/%b expected 0/1",
               bus.rf_write_addr, bus.mdu_res_ready);
    end
    idle();
  endtask

  task automatic test_zero_addr();
    bus.mdu_res_valid = 1'b1;
    bus.mdu_res_addr  = 5'd0;
    bus.mdu_res_data  = 32'hDEAD;
    settle();
    checks++;
    if (bus.mdu_res_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_ready: got %b expected 1",
               bus.mdu_res_ready);
    end
    tick();
    bus.mdu_res_valid = 1'b0;
    settle();
    checks++;
    if (bus.rf_write_addr !== 5'd0 ||
        bus.rf_data_in !== 32'd0) begin
      errors++;
      $display("FAIL zero_discard: got %0d/%h expected 0/0",
               bus.rf_write_addr, bus.rf_data_in);
    end
    tick();
    idle();
  endtask

  task automatic test_set_wins();
    bus.mdu_issue      = 1'b1;
    bus.mdu_issue_addr = 5'd7;
    tick();
    bus.mdu_issue     = 1'b0;
    bus.mdu_res_valid = 1'b1;
    bus.mdu_res_addr  = 5'd7;
    bus.mdu_res_data  = 32'h1;
    tick();
    bus.mdu_res_valid = 1'b0;
    bus.mdu_issue     = 1'b1;
    settle();
    checks++;
    if (bus.rf_write_addr !== 5'd7) begin
      errors++;
      $display("FAIL setwin_pop: got %0d expected 7",
               bus.rf_write_addr);
    end
    tick();
    bus.mdu_issue = 1'b0;
    settle();
    checks++;
    if (bus.busy_mask !== 32'h80) begin
      errors++;
      $display("FAIL setwin_busy: got %h expected 80",
               bus.busy_mask);
    end
    bus.mdu_res_valid = 1'b1;
    bus.mdu_res_data  = 32'h2;
    tick();
    bus.mdu_res_valid = 1'b0;
    tick();
    settle();
    checks++;
    if (bus.busy_mask !== 32'd0) begin
      errors++;
      $display("FAIL setwin_clear: got %h expected 0",
               bus.busy_mask);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    bus.mdu_issue      = 1'b1;
    bus.mdu_issue_addr = 5'd8;
    tick();
    bus.mdu_issue_addr = 5'd9;
    tick();
    bus.mdu_issue     = 1'b0;
    bus.pipe_wr_addr  = 5'd1;
    bus.pipe_wr_data  = 32'h1;
    bus.mdu_res_valid = 1'b1;
    bus.mdu_res_addr  = 5'd8;
    bus.mdu_res_data  = 32'h88;
    tick();
    bus.mdu_res_addr  = 5'd9;
    bus.mdu_res_data  = 32'h99;
    tick();
    bus.mdu_res_valid = 1'b0;
    settle();
    checks++;
    if (bus.busy_mask !== 32'h300 ||
        bus.rf_write_addr !== 5'd1) begin
      errors++;
      $display("FAIL mid_pre: got %h/%0d expected 300/1",
               bus.busy_mask, bus.rf_write_addr);
    end
    bus.pipe_wr_addr = 5'd0;
    rst_n = 1'b0;
    settle();
    checks++;
    if (bus.busy_mask !== 32'd0 ||
        bus.rf_write_addr !== 5'd0 ||
        bus.mdu_res_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got %h/%0d/%b expected 0/0/1",
               bus.busy_mask, bus.rf_write_addr,
               bus.mdu_res_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
    settle();
    checks++;
    if (bus.rf_write_addr !== 5'd0 || bus.drain_req !== 1'b0) begin
      errors++;
      $display("FAIL mid_after: got %0d/%b expected 0/0",
               bus.rf_write_addr, bus.drain_req);
    end
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_pipe_write();
    test_mdu_result();
    test_starvation();
    test_fifo_full();
    test_zero_addr();
    test_set_wins();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
